// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI: snapshots CP0 on acceptance, drives one TLB port for a
// single work cycle, commits results to CP0, then holds a refetch request for TLBR/TLBWI.
module tlb_op_ctrl #(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          op_valid,
  input  logic [1:0]    op_type,
  output logic          op_ready,
  output logic          op_done,
  output logic          busy,
  input  logic          flush,
  output logic          refetch_req,
  input  logic          refetch_ack,
  input  logic [31:0]   cp0_index,
  input  logic [31:0]   cp0_entryhi,
  input  logic [31:0]   cp0_entrylo0,
  input  logic [31:0]   cp0_entrylo1,
  output logic          cp0_index_we,
  output logic [31:0]   cp0_index_wdata,
  output logic          cp0_tlbr_we,
  output logic [31:0]   cp0_entryhi_wdata,
  output logic [31:0]   cp0_entrylo0_wdata,
  output logic [31:0]   cp0_entrylo1_wdata,
  output logic [18:0]   s1_vpn2,
  output logic          s1_odd_page,
  output logic [7:0]    s1_asid,
  input  logic          s1_found,
  input  logic [IW-1:0] s1_index,
  output logic [IW-1:0] r_index,
  input  logic [18:0]   r_vpn2,
  input  logic [7:0]    r_asid,
  input  logic          r_g,
  input  logic [19:0]   r_pfn0,
  input  logic [2:0]    r_c0,
  input  logic          r_d0,
  input  logic          r_v0,
  input  logic [19:0]   r_pfn1,
  input  logic [2:0]    r_c1,
  input  logic          r_d1,
  input  logic          r_v1,
  output logic          we,
  output logic [IW-1:0] w_index,
  output logic [18:0]   w_vpn2,
  output logic [7:0]    w_asid,
  output logic          w_g,
  output logic [19:0]   w_pfn0,
  output logic [2:0]    w_c0,
  output logic          w_d0,
  output logic          w_v0,
  output logic [19:0]   w_pfn1,
  output logic [2:0]    w_c1,
  output logic          w_d1,
  output logic          w_v1
);

  typedef enum logic [2:0] {StIdle, StProbe, StRead, StWrite, StCommit, StRefetch} state_e;

  state_e        state_q, state_d;
  logic [1:0]    type_q;
  logic [IW-1:0] idx_q;
  logic [18:0]   vpn2_q;
  logic [7:0]    asid_q;
  logic [25:0]   lo0_q, lo1_q;
  logic          found_q;
  logic [IW-1:0] sidx_q;
  logic [31:0]   rd_hi_q, rd_lo0_q, rd_lo1_q;
  logic          accept;

  // Only the architecturally meaningful CP0 fields are snapshotted.
  logic unused_cp0;
  assign unused_cp0 = ^{cp0_index[31:IW], cp0_entryhi[12:8], cp0_entrylo0[31:26],
                        cp0_entrylo1[31:26]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      type_q   <= 2'b00;
      idx_q    <= '0;
      vpn2_q   <= '0;
      asid_q   <= '0;
      lo0_q    <= '0;
      lo1_q    <= '0;
      found_q  <= 1'b0;
      sidx_q   <= '0;
      rd_hi_q  <= '0;
      rd_lo0_q <= '0;
      rd_lo1_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        type_q <= op_type;
        idx_q  <= cp0_index[IW-1:0];
        vpn2_q <= cp0_entryhi[31:13];
        asid_q <= cp0_entryhi[7:0];
        lo0_q  <= cp0_entrylo0[25:0];
        lo1_q  <= cp0_entrylo1[25:0];
      end
      if (state_q == StProbe) begin
        found_q <= s1_found;
        sidx_q  <= s1_index;
      end
      if (state_q == StRead) begin
        rd_hi_q  <= {r_vpn2, 5'b0, r_asid};
        rd_lo0_q <= {6'b0, r_pfn0, r_c0, r_d0, r_v0, r_g};
        rd_lo1_q <= {6'b0, r_pfn1, r_c1, r_d1, r_v1, r_g};
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    op_ready           = (state_q == StIdle) & ~flush;
    accept             = op_ready & op_valid;
    op_done            = 1'b0;
    busy               = (state_q != StIdle);
    refetch_req        = 1'b0;
    cp0_index_we       = 1'b0;
    cp0_index_wdata    = '0;
    cp0_tlbr_we        = 1'b0;
    cp0_entryhi_wdata  = '0;
    cp0_entrylo0_wdata = '0;
    cp0_entrylo1_wdata = '0;
    s1_vpn2            = '0;
    s1_odd_page        = 1'b0;
    s1_asid            = '0;
    r_index            = '0;
    we                 = 1'b0;
    w_index            = '0;
    w_vpn2             = '0;
    w_asid             = '0;
    w_g                = 1'b0;
    {w_pfn0, w_c0, w_d0, w_v0} = '0;
    {w_pfn1, w_c1, w_d1, w_v1} = '0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (op_type)
            2'b01:   state_d = StProbe;
            2'b10:   state_d = StRead;
            2'b11:   state_d = StWrite;
            default: state_d = StCommit;
          endcase
        end
      end
      StProbe: begin
        s1_vpn2 = vpn2_q;
        s1_asid = asid_q;
        state_d = flush ? StIdle : StCommit;
      end
      StRead: begin
        r_index = idx_q;
        state_d = flush ? StIdle : StCommit;
      end
      StWrite: begin
        // Gating by flush keeps a squashed TLBWI from touching the TLB.
        we                         = ~flush;
        w_index                    = idx_q;
        w_vpn2                     = vpn2_q;
        w_asid                     = asid_q;
        w_g                        = lo0_q[0] & lo1_q[0];
        {w_pfn0, w_c0, w_d0, w_v0} = lo0_q[25:1];
        {w_pfn1, w_c1, w_d1, w_v1} = lo1_q[25:1];
        state_d                    = flush ? StIdle : StCommit;
      end
      StCommit: begin
        op_done = 1'b1;
        if (type_q == 2'b01) begin
          cp0_index_we    = 1'b1;
          cp0_index_wdata = {~found_q, {(31-IW){1'b0}}, found_q ? sidx_q : {IW{1'b0}}};
        end
        if (type_q == 2'b10) begin
          cp0_tlbr_we        = 1'b1;
          cp0_entryhi_wdata  = rd_hi_q;
          cp0_entrylo0_wdata = rd_lo0_q;
          cp0_entrylo1_wdata = rd_lo1_q;
        end
        state_d = type_q[1] ? StRefetch : StIdle;
      end
      StRefetch: begin
        refetch_req = 1'b1;
        if (refetch_ack || flush) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Self-checking bench for tlb_op_ctrl: behavioural 16-entry TLB, a directed vector table,
// hand-written reset/stuck-ack sequences and randomized ops against a reference TLB image.
module tb_tlb_op_ctrl;
  localparam int TLBNUM = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic resetn, op_valid, op_ready, op_done, busy, flush, refetch_req, refetch_ack;
  logic [1:0] op_type;
  logic [31:0] cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
  logic cp0_index_we, cp0_tlbr_we;
  logic [31:0] cp0_index_wdata, cp0_entryhi_wdata, cp0_entrylo0_wdata, cp0_entrylo1_wdata;
  logic [18:0] s1_vpn2, r_vpn2, w_vpn2;
  logic s1_odd_page, s1_found, r_g, r_d0, r_v0, r_d1, r_v1, we, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [7:0] s1_asid, r_asid, w_asid;
  logic [IW-1:0] s1_index, r_index, w_index;
  logic [19:0] r_pfn0, r_pfn1, w_pfn0, w_pfn1;
  logic [2:0] r_c0, r_c1, w_c0, w_c1;

  always #5 clk = ~clk;

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready),
    .op_done(op_done), .busy(busy), .flush(flush), .refetch_req(refetch_req),
    .refetch_ack(refetch_ack), .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
    .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1), .cp0_index_we(cp0_index_we),
    .cp0_index_wdata(cp0_index_wdata), .cp0_tlbr_we(cp0_tlbr_we),
    .cp0_entryhi_wdata(cp0_entryhi_wdata), .cp0_entrylo0_wdata(cp0_entrylo0_wdata),
    .cp0_entrylo1_wdata(cp0_entrylo1_wdata), .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page),
    .s1_asid(s1_asid), .s1_found(s1_found), .s1_index(s1_index), .r_index(r_index),
    .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g), .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0),
    .r_v0(r_v0), .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1), .we(we),
    .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g), .w_pfn0(w_pfn0),
    .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0), .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1),
    .w_v1(w_v1)
  );

  // Environment TLB, written only through the DUT write port. Entries kept as CP0-format words.
  logic [31:0] tlb_hi [TLBNUM];
  logic [31:0] tlb_lo0 [TLBNUM];
  logic [31:0] tlb_lo1 [TLBNUM];

  always @(posedge clk) begin
    if (we) begin
      tlb_hi[w_index]  <= {w_vpn2, 5'b0, w_asid};
      tlb_lo0[w_index] <= {6'b0, w_pfn0, w_c0, w_d0, w_v0, w_g};
      tlb_lo1[w_index] <= {6'b0, w_pfn1, w_c1, w_d1, w_v1, w_g};
    end
  end

  always_comb begin
    s1_found = 1'b0;
    s1_index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (tlb_hi[i][31:13] == s1_vpn2 && (tlb_lo0[i][0] || tlb_hi[i][7:0] == s1_asid)) begin
        s1_found = 1'b1;
        s1_index = IW'(i);
      end
    end
  end

  assign {r_vpn2, r_asid} = {tlb_hi[r_index][31:13], tlb_hi[r_index][7:0]};
  assign r_g = tlb_lo0[r_index][0];
  assign {r_pfn0, r_c0, r_d0, r_v0} = tlb_lo0[r_index][25:1];
  assign {r_pfn1, r_c1, r_d1, r_v1} = tlb_lo1[r_index][25:1];

  // Reference image of what the TLB should hold, updated from committed TLBWI requests.
  logic [31:0] ref_hi [TLBNUM];
  logic [31:0] ref_lo0 [TLBNUM];
  logic [31:0] ref_lo1 [TLBNUM];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_ready"}, op_ready, 1);
    chk({name, "_ctl"}, {busy, op_done, refetch_req, we, cp0_index_we, cp0_tlbr_we}, 0);
    chk({name, "_wdata"}, {cp0_index_wdata, cp0_entryhi_wdata, cp0_entrylo0_wdata,
                           cp0_entrylo1_wdata}, 0);
    chk({name, "_ports"}, {s1_vpn2, s1_odd_page, s1_asid, r_index, w_index, w_vpn2, w_asid,
                           w_g, w_pfn0, w_pfn1}, 0);
  endtask

  function automatic logic [31:0] ref_probe(input logic [31:0] hi);
    for (int i = 0; i < TLBNUM; i++)
      if (ref_hi[i][31:13] == hi[31:13] && (ref_lo0[i][0] || ref_hi[i][7:0] == hi[7:0]))
        return 32'(i);
    return 32'h8000_0000;
  endfunction

  // One complete operation; flush_at: 1 = flush in work cycle, 2 = flush in COMMIT.
  task automatic do_op(input logic [1:0] t, input logic [31:0] idx, hi, lo0, lo1,
                       input int flush_at, input int ack_cyc, input bit ack_flush,
                       input logic [31:0] e_iw, e_hi, e_lo0, e_lo1);
    logic [3:0] ei;
    logic g;
    ei = idx[3:0];
    g  = lo0[0] & lo1[0];
    @(negedge clk);
    op_valid = 1'b1; op_type = t; flush = 1'b0; refetch_ack = 1'b0;
    cp0_index = idx; cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1;
    #1 chk("accept_ready", {op_ready, busy}, 2'b10);
    @(negedge clk);
    op_valid = 1'b0; op_type = 2'($urandom);
    cp0_index = $urandom; cp0_entryhi = $urandom; cp0_entrylo0 = $urandom;
    cp0_entrylo1 = $urandom;
    if (t != 2'b00) begin
      flush = (flush_at == 1);
      #1;
      chk("work_ctl", {busy, op_ready, op_done, cp0_index_we, cp0_tlbr_we, refetch_req},
          6'b100000);
      chk("work_we", we, (t == 2'b11) && (flush_at != 1));
      chk("work_s1", {s1_vpn2, s1_odd_page, s1_asid},
          (t == 2'b01) ? {hi[31:13], 1'b0, hi[7:0]} : 28'h0);
      chk("work_r", r_index, (t == 2'b10) ? ei : 4'h0);
      chk("work_w", {w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
                     w_pfn1, w_c1, w_d1, w_v1},
          (t == 2'b11) ? {ei, hi[31:13], hi[7:0], g, lo0[25:1], lo1[25:1]} : 82'h0);
      if (flush_at == 1) begin
        @(negedge clk);
        flush = 1'b0;
        #1 chk_idle("flushed");
        if (t == 2'b11) chk("tlb_entry_kept", {tlb_hi[ei], tlb_lo0[ei], tlb_lo1[ei]},
                            {ref_hi[ei], ref_lo0[ei], ref_lo1[ei]});
        return;
      end
      @(negedge clk);
    end
    flush = (flush_at == 2);
    refetch_ack = 1'($urandom_range(0, 1));
    #1;
    chk("commit_ctl", {op_done, busy, cp0_index_we, cp0_tlbr_we, we, refetch_req, op_ready},
        {2'b11, t == 2'b01, t == 2'b10, 3'b000});
    chk("commit_index", cp0_index_wdata, (t == 2'b01) ? e_iw : 32'h0);
    chk("commit_tlbr", {cp0_entryhi_wdata, cp0_entrylo0_wdata, cp0_entrylo1_wdata},
        (t == 2'b10) ? {e_hi, e_lo0, e_lo1} : 96'h0);
    chk("commit_ports", {s1_vpn2, s1_asid, r_index, w_index, w_vpn2}, 0);
    if (t == 2'b11) begin
      ref_hi[ei]  = hi & 32'hFFFF_E0FF;
      ref_lo0[ei] = (lo0 & 32'h03FF_FFFE) | {31'b0, g};
      ref_lo1[ei] = (lo1 & 32'h03FF_FFFE) | {31'b0, g};
      chk("tlb_entry", {tlb_hi[ei], tlb_lo0[ei], tlb_lo1[ei]},
          {ref_hi[ei], ref_lo0[ei], ref_lo1[ei]});
    end
    @(negedge clk);
    flush = 1'b0; refetch_ack = 1'b0;
    if (t[1]) begin
      // New requests during REFETCH must not be accepted.
      op_valid = 1'b1; op_type = 2'b00;
      for (int k = 0; k < ack_cyc; k++) begin
        if (k == ack_cyc - 1) begin
          if (ack_flush) flush = 1'b1;
          else refetch_ack = 1'b1;
        end
        #1 chk("refetch", {refetch_req, op_ready, busy, op_done, we}, 5'b10100);
        @(negedge clk);
      end
      op_valid = 1'b0; flush = 1'b0; refetch_ack = 1'b0;
    end
    #1 chk_idle("post_op");
  endtask

  task automatic run_ref(input logic [1:0] t, input logic [31:0] idx, hi, lo0, lo1,
                         input int flush_at, input int ack_cyc, input bit ack_flush);
    logic [3:0] ei;
    ei = idx[3:0];
    do_op(t, idx, hi, lo0, lo1, flush_at, ack_cyc, ack_flush,
          ref_probe(hi), ref_hi[ei], ref_lo0[ei], ref_lo1[ei]);
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [31:0] idx, hi, lo0, lo1;
    int          flush_at;
    int          ack_cyc;
    logic [31:0] e_iw, e_hi, e_lo0, e_lo1;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{2'b11, 32'd5,  32'h2468A03A, 32'h00040016, 32'h0004005F, 0, 1, 0, 0, 0, 0};
    vecs[1]  = '{2'b01, 32'd0,  32'h2468A03A, 32'h0, 32'h0, 0, 1, 32'h00000005, 0, 0, 0};
    vecs[2]  = '{2'b01, 32'd0,  32'h2468A03B, 32'h0, 32'h0, 0, 1, 32'h80000000, 0, 0, 0};
    vecs[3]  = '{2'b11, 32'd5,  32'h2468A03A, 32'h00040017, 32'h0004005F, 0, 2, 0, 0, 0, 0};
    vecs[4]  = '{2'b01, 32'd0,  32'h2468A03B, 32'h0, 32'h0, 0, 1, 32'h00000005, 0, 0, 0};
    vecs[5]  = '{2'b11, 32'd9,  32'h10000001, 32'h00040017, 32'h0004005F, 0, 3, 0, 0, 0, 0};
    vecs[6]  = '{2'b10, 32'd9,  32'h0, 32'h0, 32'h0, 0, 1,
                 0, 32'h10000001, 32'h00040017, 32'h0004005F};
    vecs[7]  = '{2'b11, 32'd9,  32'h55555555, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0};
    vecs[8]  = '{2'b10, 32'h29, 32'h0, 32'h0, 32'h0, 0, 2,
                 0, 32'h10000001, 32'h00040017, 32'h0004005F};
    vecs[9]  = '{2'b01, 32'd0,  32'h2468A03A, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0};
    vecs[10] = '{2'b00, 32'd3,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 0};
    vecs[11] = '{2'b10, 32'd9,  32'h0, 32'h0, 32'h0, 2, 1,
                 0, 32'h10000001, 32'h00040017, 32'h0004005F};
    vecs[12] = '{2'b01, 32'd0,  32'h10000001, 32'h0, 32'h0, 2, 1, 32'h00000009, 0, 0, 0};

    resetn = 1'b0; op_valid = 1'b0; op_type = 2'b00; flush = 1'b0; refetch_ack = 1'b0;
    cp0_index = '0; cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1 chk_idle("reset");
    flush = 1'b1;
    #1 chk("ready_flush", op_ready, 0);
    flush = 1'b0;

    // Fill every entry with distinct VPN2s away from the directed values.
    for (int i = 0; i < TLBNUM; i++)
      run_ref(2'b11, 32'(i), ((32'h40000 + 32'(i)) << 13) | 32'(i), $urandom, $urandom, 0, 1, 0);

    for (int v = 0; v < 13; v++)
      do_op(vecs[v].t, vecs[v].idx, vecs[v].hi, vecs[v].lo0, vecs[v].lo1, vecs[v].flush_at,
            vecs[v].ack_cyc, 1'b0, vecs[v].e_iw, vecs[v].e_hi, vecs[v].e_lo0, vecs[v].e_lo1);

    // Ack stuck low for 10 REFETCH cycles, then taken on the 11th.
    run_ref(2'b11, 32'd7, 32'h0ABCD0EE, 32'h00001235, 32'h00002343, 0, 11, 0);

    // Reset while refetch_req is high.
    @(negedge clk);
    op_valid = 1'b1; op_type = 2'b10; cp0_index = 32'd9;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("pre_reset_refetch", refetch_req, 1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1 chk_idle("reset_mid_refetch");

    for (int n = 0; n < 150; n++) begin
      logic [1:0]  t;
      logic [31:0] hi;
      int          sel, fa;
      t   = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 3);
      case (sel)
        0:       hi = (32'h40000 + 32'($urandom_range(0, 15))) << 13;
        1:       hi = 32'h2468A000;
        2:       hi = 32'h10000000;
        default: hi = $urandom & 32'hFFFF_E000;
      endcase
      hi = hi | ($urandom_range(0, 1) != 0 ? 32'($urandom_range(0, 15)) : 32'h3B);
      fa = $urandom_range(0, 9);
      fa = (fa < 2) ? 1 : (fa == 2) ? 2 : 0;
      run_ref(t, $urandom, hi, $urandom, $urandom, fa, $urandom_range(1, 4),
              1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer for the privileged TLB instructions TLBP, TLBR and TLBWI. Sits between the pipeline's write-back stage, CP0 and the 16-entry TLB. It accepts one TLB operation at a time, drives the TLB search port 1, read port or write port over a fixed multi-cycle sequence, and returns the results to CP0. After TLBR or TLBWI it holds a refetch request so later instructions see the new mapping or ASID.

## Interface

- TLBNUM, 16, TLB entry count; IW = $clog2(TLBNUM)
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  synchronous, active-low reset
- op_valid  in  1  operation request from WB
- op_type  in  2  01 TLBP, 10 TLBR, 11 TLBWI, 00 reserved (no-op)
- op_ready  out  1  request accepted this cycle when op_valid=1
- op_done  out  1  one-cycle pulse: operation architecturally committed
- busy  out  1  state != IDLE; pipeline stalls on it
- flush  in  1  exception/ERET flush from WB
- refetch_req  out  1  pipeline must refetch from the instruction after the op
- refetch_ack  in  1  refetch has been taken
- cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1  in  32 each  current CP0 values
- cp0_index_we  out  1  write cp0_index_wdata into Index
- cp0_index_wdata  out  32  {~found, 31-IW zeros, index}
- cp0_tlbr_we  out  1  write EntryHi, EntryLo0 and EntryLo1 together
- cp0_entryhi_wdata  out  32  {vpn2, 5'b0, asid}
- cp0_entrylo0_wdata, cp0_entrylo1_wdata  out  32 each  {6'b0, pfn, c, d, v, g}
- s1_vpn2  out  19; s1_odd_page  out  1; s1_asid  out  8  TLB search port 1
- s1_found  in  1; s1_index  in  IW  TLB search results
- r_index  out  IW; r_vpn2, r_asid, r_g, r_pfn0/1, r_c0/1, r_d0/1, r_v0/1  in  TLB read port
- we  out  1; w_index  out  IW; w_vpn2, w_asid, w_g, w_pfn0/1, w_c0/1, w_d0/1, w_v0/1  out  TLB write port

## Operation

- States: IDLE, PROBE, READ, WRITE, COMMIT, REFETCH.
- op_ready = (state==IDLE) & ~flush. On acceptance:
  - latch op_type, cp0_index, entryhi, entrylo0 and entrylo1 into snapshot registers;
  - next state is PROBE (01), READ (10), WRITE (11) or COMMIT (00).
- PROBE: s1_vpn2 = snap_hi[31:13], s1_asid = snap_hi[7:0], s1_odd_page = 0. Register s1_found and s1_index, then go to COMMIT.
- READ: r_index = snap_index[IW-1:0]. Register all r_* fields, then go to COMMIT.
- WRITE: we = ~flush, w_index = snap_index[IW-1:0], w_vpn2 = snap_hi[31:13], w_asid = snap_hi[7:0], w_g = lo0.g & lo1.g, with pfn/c/d/v taken from the EntryLo fields. Then go to COMMIT.
- COMMIT: op_done = 1.
  - TLBP: cp0_index_we = 1. On a miss, bit31 = 1 and the index field is 0.
  - TLBR: cp0_tlbr_we = 1. g is replicated into bit0 of both EntryLo values.
  - Next state: REFETCH for TLBR/TLBWI, IDLE otherwise.
- REFETCH: refetch_req = 1 until refetch_ack or flush, then go to IDLE.
- flush handling:
  - PROBE/READ/WRITE: go to IDLE; no CP0 write, no op_done, no TLB write (we is gated by ~flush).
  - COMMIT: ignored.
  - REFETCH: acts as refetch_ack.
- When not in their state, search/read/write port outputs are 0 and we = 0.
- With TLBNUM=16, snap_index bits above bit 3 are ignored.

## Timing

- Reset (resetn=0 at an edge): state=IDLE, snapshots 0. Then op_ready=1 (unless flush), and busy, op_done, refetch_req, we, cp0_index_we, cp0_tlbr_we are all 0. All wdata and port outputs are 0.
- Reset takes effect at the next edge even mid-operation. An interrupted WRITE either completed at an earlier edge or not at all.
- Latency from the acceptance edge T:
  - TLBP/TLBR/TLBWI: one work cycle, then COMMIT in the second cycle, with op_done at T+2.
  - No-op: op_done at T+1.
  - TLBWI: the TLB entry is updated at the end of cycle T+1, so a search in cycle T+2 sees the new entry.
- refetch_req rises in the cycle after COMMIT and stays high until sampled with ack. REFETCH lasts at least one cycle; an ack held high during COMMIT is ignored.
- Back-to-back: the earliest next acceptance is the cycle after returning to IDLE. CP0 changes after acceptance do not affect the op in flight.

## Test plan

- TLBP hit: entry 5 holds vpn2=0x12345, asid=0x3A, g=0; EntryHi=0x2468A03A -> op_done at T+2, cp0_index_wdata=0x00000005.
- TLBP miss: EntryHi asid=0x3B, no g entry -> cp0_index_wdata=0x80000000. Same with g=1 on entry 5 -> 0x00000005.
- TLBWI then TLBR: Index=9, EntryLo0=0x00040017, EntryLo1=0x0004005F -> we for one cycle, refetch_req until ack. The following TLBR of index 9 returns EntryLo0=0x00040017 and EntryLo1=0x0004005F, since g = 1&1.
- Flush: flush asserted in the WRITE cycle -> we=0, entry unchanged, no op_done, state IDLE next cycle. Flush in PROBE -> no cp0_index_we.
- Reset mid-REFETCH: resetn=0 with refetch_req=1 -> next cycle refetch_req=0, op_ready=1, all write enables 0.
- Reserved op 00 and refetch_ack stuck at 0 for 10 cycles: 00 -> op_done at T+1 with no CP0/TLB writes. Stuck ack -> refetch_req held for 10 cycles and op_ready stays 0.
